// File: rtl/meduram_pkg.sv
// Shared types and helpers for the multi-bank RAM write-side bookkeeping.
package meduram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } wracc_state_t;

    localparam int unsigned WRCOL_CNT_W = 16;

    // Bank id width: a single bank still gets one (always-zero) bit.
    function automatic int unsigned bank_id_width(input int unsigned nb_wragent);
        return (nb_wragent <= 1) ? 1 : $clog2(nb_wragent);
    endfunction

    // Width of one bank_select entry: bank id plus optional collision flag.
    function automatic int unsigned select_width(input int unsigned nb_wragent,
                                                 input int unsigned write_collision);
        return bank_id_width(nb_wragent) + write_collision;
    endfunction

endpackage

// File: rtl/wr_collision_detect.sv
// Resolves all writers targeting one address: hit, highest-index winner, multi-writer flag.
module wr_collision_detect
    import meduram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NB_WRAGENT = 2,
    localparam int unsigned ID_W = bank_id_width(NB_WRAGENT)
) (
    input  logic [NB_WRAGENT-1:0]            m_wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] m_wraddr,
    input  logic [ADDR_WIDTH-1:0]            address,
    output logic                             hit,
    output logic [ID_W-1:0]                  winner,
    output logic                             colflag
);

    // Scan writers in ascending order so the last match is the highest index.
    always_comb begin
        hit     = 1'b0;
        winner  = '0;
        colflag = 1'b0;
        for (int unsigned w = 0; w < NB_WRAGENT; w++) begin
            if (m_wren[w] && (m_wraddr[w*ADDR_WIDTH +: ADDR_WIDTH] == address)) begin
                if (hit) begin
                    colflag = 1'b1;
                end
                hit    = 1'b1;
                winner = ID_W'(w);
            end
        end
    end

endmodule

// File: rtl/write_accounter.sv
// Write-side bookkeeping: per-address table of the bank holding the latest data.
// Optional macro WRACC_BYPASS_EN forwards same-cycle writes onto bank_select.
module write_accounter
    import meduram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned NB_WRAGENT      = 2,
    parameter int unsigned NB_RDAGENT      = 2,
    parameter int unsigned WRITE_COLLISION = 1,
    localparam int unsigned SELECT_WIDTH   = select_width(NB_WRAGENT, WRITE_COLLISION)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NB_WRAGENT-1:0]            m_wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] m_wraddr,
    input  logic [NB_RDAGENT-1:0]            m_rden,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] m_rdaddr,
    output logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select,
    output logic                             ready,
    output logic [WRCOL_CNT_W-1:0]           wrcol_count
);

    localparam int unsigned ID_W  = bank_id_width(NB_WRAGENT);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  PTR_LAST = '1;
    localparam logic [WRCOL_CNT_W-1:0] CNT_MAX  = '1;

    wracc_state_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0]      ptr_q, ptr_d;
    logic                       ready_q, ready_d;
    logic [WRCOL_CNT_W-1:0]     cnt_q, cnt_d;
    logic [SELECT_WIDTH-1:0]    table_q [DEPTH];
    logic [SELECT_WIDTH-1:0]    table_d [DEPTH];

    logic [NB_WRAGENT-1:0]      wr_hit;
    logic [NB_WRAGENT-1:0]      wr_col;
    logic [SELECT_WIDTH-1:0]    wr_val [NB_WRAGENT];
    logic                       any_col_c;

    // Read enables only qualify bank_select downstream.
    logic unused_rden;
    assign unused_rden = ^m_rden;

    // Per-writer resolution of its own address gives the entry it would store.
    for (genvar g = 0; g < int'(NB_WRAGENT); g++) begin : g_wr
        logic [ID_W-1:0] winner;

        wr_collision_detect #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .NB_WRAGENT (NB_WRAGENT)
        ) u_det (
            .m_wren   (m_wren),
            .m_wraddr (m_wraddr),
            .address  (m_wraddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .hit      (wr_hit[g]),
            .winner   (winner),
            .colflag  (wr_col[g])
        );

        if (WRITE_COLLISION != 0) begin : g_col
            assign wr_val[g] = SELECT_WIDTH'({wr_col[g], winner});
        end else begin : g_nocol
            assign wr_val[g] = SELECT_WIDTH'(winner);
        end
    end

    // Next-state: INIT sweeps the table clear, RUN applies resolved writes and counts collisions.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ready_d   = ready_q;
        cnt_d     = cnt_q;
        table_d   = table_q;
        any_col_c = |(wr_hit & wr_col);
        case (state_q)
            INIT: begin
                table_d[ptr_q] = '0;
                ptr_d          = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                for (int unsigned w = 0; w < NB_WRAGENT; w++) begin
                    if (wr_hit[w]) begin
                        table_d[m_wraddr[w*ADDR_WIDTH +: ADDR_WIDTH]] = wr_val[w];
                    end
                end
                if (any_col_c && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    // Table storage is deliberately unreset; the INIT sweep clears it.
    always_ff @(posedge aclk) begin
        table_q <= table_d;
    end

    // Combinational table lookup per read agent.
    for (genvar r = 0; r < int'(NB_RDAGENT); r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] rd_addr;
        assign rd_addr = m_rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef WRACC_BYPASS_EN
        logic                    byp_hit;
        logic [ID_W-1:0]         byp_winner;
        logic                    byp_col;
        logic [SELECT_WIDTH-1:0] byp_val;

        wr_collision_detect #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .NB_WRAGENT (NB_WRAGENT)
        ) u_byp (
            .m_wren   (m_wren),
            .m_wraddr (m_wraddr),
            .address  (rd_addr),
            .hit      (byp_hit),
            .winner   (byp_winner),
            .colflag  (byp_col)
        );

        if (WRITE_COLLISION != 0) begin : g_col
            assign byp_val = SELECT_WIDTH'({byp_col, byp_winner});
        end else begin : g_nocol
            logic unused_byp_col;
            assign unused_byp_col = byp_col;
            assign byp_val = SELECT_WIDTH'(byp_winner);
        end

        assign bank_select[r*SELECT_WIDTH +: SELECT_WIDTH] =
            ((state_q == RUN) && byp_hit) ? byp_val : table_q[rd_addr];
`else
        assign bank_select[r*SELECT_WIDTH +: SELECT_WIDTH] = table_q[rd_addr];
`endif
    end

    assign ready       = ready_q;
    assign wrcol_count = cnt_q;

endmodule

// File: tb/tb_write_accounter.sv
// Scoreboard bench for write_accounter: random/directed writes against a behavioural table model.
`timescale 1ns/1ps
module tb_write_accounter;

    localparam int unsigned AW    = 8;
    localparam int unsigned NW    = 2;
    localparam int unsigned NR    = 2;
    localparam int unsigned SW    = 2;
    localparam int unsigned DEPTH = 256;

    typedef struct packed {
        logic [NR*SW-1:0] bs;
        logic [NR-1:0]    bs_chk;
        logic [NR*AW-1:0] ra;
        logic             rdy;
        logic [15:0]      cnt;
    } exp_t;

    logic              aclk    = 1'b0;
    logic              aresetn = 1'b0;
    logic [NW-1:0]     m_wren   = '0;
    logic [NW*AW-1:0]  m_wraddr = '0;
    logic [NR-1:0]     m_rden   = '0;
    logic [NR*AW-1:0]  m_rdaddr = '0;
    logic [NR*SW-1:0]  bank_select;
    logic              ready;
    logic [15:0]       wrcol_count;

    write_accounter #(
        .ADDR_WIDTH      (AW),
        .NB_WRAGENT      (NW),
        .NB_RDAGENT      (NR),
        .WRITE_COLLISION (1)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .m_wren      (m_wren),
        .m_wraddr    (m_wraddr),
        .m_rden      (m_rden),
        .m_rdaddr    (m_rdaddr),
        .bank_select (bank_select),
        .ready       (ready),
        .wrcol_count (wrcol_count)
    );

    always #5 aclk = ~aclk;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: table of {bank, colflag} per address, plus what is known about each entry.
    int mdl_bank  [DEPTH];
    bit mdl_col   [DEPTH];
    bit mdl_known [DEPTH];
    int mdl_idx;
    bit mdl_run;
    bit mdl_ready;
    int mdl_cnt;

    function automatic logic [AW-1:0] a_small();
        return AW'($urandom_range(0, 15));
    endfunction

    function automatic logic [AW-1:0] a_full();
        return AW'($urandom);
    endfunction

    function automatic logic [2*AW-1:0] pk(input logic [AW-1:0] hi, input logic [AW-1:0] lo);
        return {hi, lo};
    endfunction

    // Writers to one address: highest enabled index wins, two or more means a collision.
    task automatic resolve(input logic [NW-1:0] wren, input logic [NW*AW-1:0] wa,
                           input logic [AW-1:0] a, output bit hit, output int bank, output bit col);
        int n = 0;
        bank = 0;
        for (int w = 0; w < int'(NW); w++) begin
            if (wren[w] && (wa[w*AW +: AW] == a)) begin
                n++;
                bank = w;
            end
        end
        hit = (n > 0);
        col = (n >= 2);
    endtask

    task automatic model_reset();
        mdl_idx      = 0;
        mdl_run      = 1'b0;
        mdl_ready    = 1'b0;
        mdl_cnt      = 0;
        mdl_known[0] = 1'b0;
    endtask

    // One cycle: drive inputs, push expected outputs, then advance the model across the edge.
    task automatic step(input logic [NW-1:0] wren, input logic [NW*AW-1:0] wa,
                        input logic [NR*AW-1:0] ra);
        exp_t          e;
        bit            hit;
        bit            col;
        bit            any_col;
        int            bank;
        logic [AW-1:0] a;
        m_wren   = wren;
        m_wraddr = wa;
        m_rdaddr = ra;
        m_rden   = NR'($urandom);
        e        = '0;
        e.rdy    = mdl_ready;
        e.cnt    = 16'(mdl_cnt);
        e.ra     = ra;
        for (int r = 0; r < int'(NR); r++) begin
            a = ra[r*AW +: AW];
            if (mdl_known[a]) begin
                e.bs_chk[r]       = 1'b1;
                e.bs[r*SW +: SW]  = {mdl_col[a], 1'(mdl_bank[a])};
            end
`ifdef WRACC_BYPASS_EN
            if (mdl_run) begin
                resolve(wren, wa, a, hit, bank, col);
                if (hit) begin
                    e.bs_chk[r]      = 1'b1;
                    e.bs[r*SW +: SW] = {col, 1'(bank)};
                end
            end
`endif
        end
        sb_q.push_back(e);
        @(posedge aclk);
        #1;
        if (aresetn) begin
            if (!mdl_run) begin
                mdl_bank[mdl_idx]  = 0;
                mdl_col[mdl_idx]   = 1'b0;
                mdl_known[mdl_idx] = 1'b1;
                mdl_idx++;
                if (mdl_idx == int'(DEPTH)) begin
                    mdl_run   = 1'b1;
                    mdl_ready = 1'b1;
                end
            end else begin
                any_col = 1'b0;
                for (int w = 0; w < int'(NW); w++) begin
                    if (wren[w]) begin
                        a = wa[w*AW +: AW];
                        resolve(wren, wa, a, hit, bank, col);
                        if (hit) begin
                            mdl_bank[a]  = bank;
                            mdl_col[a]   = col;
                            mdl_known[a] = 1'b1;
                            any_col      = any_col | col;
                        end
                    end
                end
                if (any_col && (mdl_cnt < 65535)) begin
                    mdl_cnt++;
                end
            end
        end
    endtask

    task automatic step_rand_small();
        step(NW'($urandom), pk(a_small(), a_small()), pk(a_small(), a_small()));
    endtask

    // Monitor: compare DUT outputs against the oldest expectation, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (ready !== e.rdy) begin
                    failures++;
                    $display("FAIL ready t=%0t got=%0b exp=%0b", $time, ready, e.rdy);
                end
                checks++;
                if (wrcol_count !== e.cnt) begin
                    failures++;
                    $display("FAIL wrcol_count t=%0t got=%0h exp=%0h", $time, wrcol_count, e.cnt);
                end
                for (int r = 0; r < int'(NR); r++) begin
                    if (e.bs_chk[r]) begin
                        checks++;
                        if (bank_select[r*SW +: SW] !== e.bs[r*SW +: SW]) begin
                            failures++;
                            $display("FAIL bank_select[%0d] addr=%0h t=%0t got=%0h exp=%0h",
                                     r, e.ra[r*AW +: AW], $time, bank_select[r*SW +: SW],
                                     e.bs[r*SW +: SW]);
                        end
                    end
                end
            end
        end
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        model_reset();
        @(posedge aclk);
        #1;
        // Reset held, then the first sweep with idle writers.
        repeat (3) step('0, '0, pk(a_full(), a_full()));
        aresetn = 1'b1;
        repeat (DEPTH) step('0, '0, pk(a_full(), a_full()));
        repeat (64) step('0, '0, pk(a_full(), a_full()));

        // Single writer, then read back.
        step(2'b10, pk(8'h10, 8'h00), pk(8'h10, 8'h10));
        step(2'b00, '0, pk(8'h10, 8'h10));

        // Two writers collide on one address; then a lone writer clears the flag.
        step(2'b11, pk(8'h20, 8'h20), pk(8'h20, 8'h20));
        step(2'b00, '0, pk(8'h20, 8'h20));
        step(2'b01, pk(8'h00, 8'h20), pk(8'h20, 8'h20));
        step(2'b00, '0, pk(8'h20, 8'h20));

        // Distinct addresses in the same cycle.
        step(2'b11, pk(8'h02, 8'h01), pk(8'h02, 8'h01));
        step(2'b00, '0, pk(8'h02, 8'h01));

        // Random traffic over a narrow address range to force frequent collisions.
        repeat (2000) step_rand_small();

        // Continuous collisions drive the counter to saturation and hold it there.
        repeat (65600) begin
            a = a_small();
            step(2'b11, pk(a, a), pk(a_small(), a));
        end
        repeat (20) step_rand_small();

        // Reset in RUN, then again partway through the sweep, with writes attempted during INIT.
        aresetn = 1'b0;
        model_reset();
        repeat (2) step_rand_small();
        aresetn = 1'b1;
        repeat (100) step(NW'($urandom), pk(a_full(), a_full()), pk(a_full(), a_full()));
        aresetn = 1'b0;
        model_reset();
        repeat (2) step_rand_small();
        aresetn = 1'b1;
        repeat (DEPTH) step(NW'($urandom), pk(a_full(), a_full()), pk(a_full(), a_full()));
        repeat (300) step_rand_small();

        @(negedge aclk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
